// File: rtl/spi_xfer_ctrl_if.sv
// Handshake bundle between spi_xfer_ctrl, its host (TX/RX byte streams) and spi_master.
// The slave modport is the controller's view; master is the view of whatever drives it.
interface spi_xfer_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       m_start;
  logic [7:0] m_tx_data;
  logic [7:0] m_rx_data;
  logic       m_busy;
  logic       m_done;

  modport slave (
    input  in_data, in_valid, out_ready, m_rx_data, m_busy, m_done,
    output in_ready, out_data, out_valid, m_start, m_tx_data
  );

  modport master (
    output in_data, in_valid, out_ready, m_rx_data, m_busy, m_done,
    input  in_ready, out_data, out_valid, m_start, m_tx_data
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// Byte-stream front end for spi_master: TX FIFO -> one master transfer per byte -> RX FIFO.
// Optional macro SPI_RX_BACKPRESSURE_EN: hold launches until RX has a free slot (rx_ovf tied 0).
module spi_xfer_ctrl #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  spi_xfer_ctrl_if.slave            bus,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  output logic                      rx_ovf,
  output logic                      tmo_err,
  output logic                      idle
);
  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int RXAW = $clog2(RX_DEPTH);
  localparam logic [TXAW:0] TX_FULL    = (TXAW+1)'(TX_DEPTH);
  localparam logic [RXAW:0] RX_FULL    = (RXAW+1)'(RX_DEPTH);
  localparam logic [31:0]   WAIT_LIMIT = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t          r_state;
  logic            r_m_start;
  logic [7:0]      r_m_tx_data;
  logic [31:0]     r_wait_cnt;
  logic            r_tmo_err;

  logic [7:0]      r_tx_mem [TX_DEPTH];
  logic [TXAW-1:0] r_tx_wr;
  logic [TXAW-1:0] r_tx_rd;
  logic [TXAW:0]   r_tx_cnt;

  logic [7:0]      r_rx_mem [RX_DEPTH];
  logic [RXAW-1:0] r_rx_wr;
  logic [RXAW-1:0] r_rx_rd;
  logic [RXAW:0]   r_rx_cnt;

  logic w_tx_push;
  logic w_tx_pop;
  logic w_launch_ok;
  logic w_rx_capture;
  logic w_rx_full;
  logic w_rx_pop;
  logic w_rx_push;

  assign w_tx_push    = bus.in_valid && (r_tx_cnt != TX_FULL);
  assign w_tx_pop     = (r_state == S_IDLE) && (r_tx_cnt != '0) && !bus.m_busy && w_launch_ok;
  assign w_rx_capture = (r_state == S_WAIT) && bus.m_done;
  assign w_rx_full    = (r_rx_cnt == RX_FULL);
  assign w_rx_pop     = (r_rx_cnt != '0) && bus.out_ready;
  // A full RX still accepts a byte when the host pops the head in the same cycle.
  assign w_rx_push    = w_rx_capture && (!w_rx_full || w_rx_pop);

`ifdef SPI_RX_BACKPRESSURE_EN
  logic w_pending;
  assign w_pending   = (r_state != S_IDLE);
  assign w_launch_ok = ((r_rx_cnt + {{RXAW{1'b0}}, w_pending}) < RX_FULL);
  assign rx_ovf      = 1'b0;
`else
  logic r_rx_ovf;
  assign w_launch_ok = 1'b1;
  assign rx_ovf      = r_rx_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_ovf <= 1'b0;
    end else if (w_rx_capture && w_rx_full && !w_rx_pop) begin
      r_rx_ovf <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TX_DEPTH; i++) r_tx_mem[i] <= '0;
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wr] <= bus.in_data;
        r_tx_wr           <= r_tx_wr + TXAW'(1);
      end
      if (w_tx_pop) begin
        r_tx_rd <= r_tx_rd + TXAW'(1);
      end
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + (TXAW+1)'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - (TXAW+1)'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RX_DEPTH; i++) r_rx_mem[i] <= '0;
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wr] <= bus.m_rx_data;
        r_rx_wr           <= r_rx_wr + RXAW'(1);
      end
      if (w_rx_pop) begin
        r_rx_rd <= r_rx_rd + RXAW'(1);
      end
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + (RXAW+1)'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - (RXAW+1)'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // Timeout fires at the end of the TIMEOUT-th WAIT cycle; m_done in that cycle still wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_m_start   <= 1'b0;
      r_m_tx_data <= '0;
      r_wait_cnt  <= '0;
      r_tmo_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tx_pop) begin
            r_m_tx_data <= r_tx_mem[r_tx_rd];
            r_m_start   <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          r_m_start  <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.m_done) begin
            r_state <= S_IDLE;
          end else if ((TIMEOUT != 0) && (r_wait_cnt >= WAIT_LIMIT)) begin
            r_tmo_err <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
          end
        end
        default: begin
          r_m_start <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_tx_cnt != TX_FULL);
  assign bus.out_data  = r_rx_mem[r_rx_rd];
  assign bus.out_valid = (r_rx_cnt != '0);
  assign bus.m_start   = r_m_start;
  assign bus.m_tx_data = r_m_tx_data;
  assign tx_level      = r_tx_cnt;
  assign rx_level      = r_rx_cnt;
  assign tmo_err       = r_tmo_err;
  assign idle          = (r_state == S_IDLE) && (r_tx_cnt == '0);
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl against a behavioural spi_master model and
// queue-based expectations; honours SPI_RX_BACKPRESSURE_EN when defined.
module tb_spi_xfer_ctrl;
  localparam int TxDepth = 8;
  localparam int RxDepth = 8;
  localparam int Timeout = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] txLevel;
  logic [3:0] rxLevel;
  logic       rxOvf;
  logic       tmoErr;
  logic       idle;

  spi_xfer_ctrl_if bus();

  spi_xfer_ctrl #(.TX_DEPTH(TxDepth), .RX_DEPTH(RxDepth), .TIMEOUT(Timeout)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .tx_level(txLevel), .rx_level(rxLevel),
    .rx_ovf(rxOvf), .tmo_err(tmoErr), .idle(idle)
  );

  always #5 clk = ~clk;

  int checksTotal = 0;
  int checksPassed = 0;

  bit holdBusy = 1'b0;
  bit neverDone = 1'b0;
  int spuriousReq = 0;
  int spuriousAck = 0;
  byte unsigned respQ[$];
  byte unsigned startLog[$];
  byte unsigned doneResp[$];

  int negCount = 0;
  int lastDoneNeg = -100;
  int busyCnt = 0;
  bit active = 1'b0;
  bit startSeenLast = 1'b0;
  byte unsigned heldTx = 0;
  int gapFlag = 0;
  int wideFlag = 0;
  int holdFlag = 0;

  // spi_master stand-in: busy from start until done, done after a random 1..6 cycles.
  always @(negedge clk) begin
    negCount++;
    if (!rst_n) begin
      bus.m_busy = 1'b0;
      bus.m_done = 1'b0;
      bus.m_rx_data = 8'h00;
      active = 1'b0;
      startSeenLast = 1'b0;
    end else if (holdBusy) begin
      bus.m_busy = 1'b1;
      bus.m_done = 1'b0;
    end else begin
      bus.m_done = 1'b0;
      if (!active) bus.m_busy = 1'b0;
      if (bus.m_start) begin
        if (startSeenLast) wideFlag++;
        if (negCount - lastDoneNeg < 2) gapFlag++;
        startLog.push_back(bus.m_tx_data);
        heldTx = bus.m_tx_data;
        active = 1'b1;
        bus.m_busy = 1'b1;
        busyCnt = $urandom_range(1, 6);
      end else if (active) begin
        if (bus.m_tx_data !== heldTx) holdFlag++;
        if (!neverDone) begin
          if (busyCnt > 1) begin
            busyCnt--;
          end else begin
            active = 1'b0;
            bus.m_busy = 1'b0;
            bus.m_done = 1'b1;
            bus.m_rx_data = (respQ.size() > 0) ? respQ.pop_front() : 8'($urandom);
            doneResp.push_back(bus.m_rx_data);
            lastDoneNeg = negCount;
          end
        end
      end else if (spuriousReq != spuriousAck) begin
        spuriousAck = spuriousReq;
        bus.m_done = 1'b1;
        bus.m_rx_data = 8'hEE;
      end
      startSeenLast = bus.m_start;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    assert (observed === expected) checksPassed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic failBound(input string tag);
    checksTotal++;
    $error("[TB] FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic applyStimulus(input byte unsigned b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) failBound("push_ready_wait");
    bus.in_data = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    holdBusy = 1'b0;
    neverDone = 1'b0;
    respQ.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic waitRxLevel(input int lvl, input string tag);
    int n = 0;
    while (int'(rxLevel) != lvl && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) failBound(tag);
  endtask

  task automatic popOne(output byte unsigned b);
    b = bus.out_data;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    byte unsigned sent[$];
    byte unsigned popped[$];
    byte unsigned resp[10];
    byte unsigned b;
    int startBase;
    int doneBase;
    int n;

    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) tick();

    $display("[TB] reset values");
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_m_start", bus.m_start, 0);
    checkOutput("rst_m_tx_data", bus.m_tx_data, 0);
    checkOutput("rst_tx_level", txLevel, 0);
    checkOutput("rst_rx_level", rxLevel, 0);
    checkOutput("rst_rx_ovf", rxOvf, 0);
    checkOutput("rst_tmo_err", tmoErr, 0);
    checkOutput("rst_idle", idle, 1);
    rst_n = 1'b1;
    tick();

    $display("[TB] single byte");
    respQ.push_back(8'hA5);
    applyStimulus(8'h3C);
    waitRxLevel(1, "t1_rx_wait");
    checkOutput("t1_start_count", startLog.size(), 1);
    checkOutput("t1_tx_byte", startLog[0], 8'h3C);
    checkOutput("t1_out_data", bus.out_data, 8'hA5);
    checkOutput("t1_rx_level", rxLevel, 1);
    checkOutput("t1_idle", idle, 1);
    popOne(b);
    checkOutput("t1_rx_after_pop", rxLevel, 0);

    $display("[TB] random stream");
    startBase = startLog.size();
    doneBase = doneResp.size();
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          b = 8'($urandom);
          sent.push_back(b);
          applyStimulus(b);
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin
        for (int t = 0; t < 3000 && popped.size() < 24; t++) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          if (bus.out_valid && bus.out_ready) popped.push_back(bus.out_data);
          tick();
        end
        bus.out_ready = 1'b0;
      end
    join
    checkOutput("t2_pop_count", popped.size(), 24);
    checkOutput("t2_start_count", startLog.size() - startBase, 24);
    for (int i = 0; i < 24 && i < popped.size() && doneBase + i < doneResp.size(); i++)
      checkOutput($sformatf("t2_rx_%0d", i), popped[i], doneResp[doneBase + i]);
    for (int i = 0; i < 24 && startBase + i < startLog.size(); i++)
      checkOutput($sformatf("t2_tx_%0d", i), startLog[startBase + i], sent[i]);
    checkOutput("t2_rx_ovf", rxOvf, 0);
    checkOutput("t2_start_gap", gapFlag, 0);
    checkOutput("t2_start_width", wideFlag, 0);
    checkOutput("t2_tx_hold", holdFlag, 0);

    $display("[TB] spurious done while idle");
    spuriousReq++;
    repeat (3) tick();
    checkOutput("sp_rx_level", rxLevel, 0);
    checkOutput("sp_out_valid", bus.out_valid, 0);

    $display("[TB] TX full with master busy");
    doReset();
    holdBusy = 1'b1;
    tick();
    startBase = startLog.size();
    for (int i = 0; i < TxDepth; i++) applyStimulus(8'(8'h40 + i));
    checkOutput("t3_in_ready", bus.in_ready, 0);
    checkOutput("t3_tx_level", txLevel, 8);
    bus.in_data = 8'h99;
    bus.in_valid = 1'b1;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    checkOutput("t3_tx_level_hold", txLevel, 8);
    checkOutput("t3_no_start", startLog.size() - startBase, 0);

    $display("[TB] RX full behaviour");
    doReset();
    startBase = startLog.size();
    for (int i = 0; i < 10; i++) begin
      resp[i] = 8'($urandom);
      respQ.push_back(resp[i]);
    end
    for (int i = 0; i < RxDepth; i++) applyStimulus(8'(8'h60 + i));
    waitRxLevel(8, "t4_fill_wait");
    checkOutput("t4_full_level", rxLevel, 8);
    checkOutput("t4_full_ovf", rxOvf, 0);
    checkOutput("t4_full_starts", startLog.size() - startBase, 8);
    applyStimulus(8'h68);
`ifdef SPI_RX_BACKPRESSURE_EN
    repeat (40) tick();
    checkOutput("t4_bp_tx_level", txLevel, 1);
    checkOutput("t4_bp_starts", startLog.size() - startBase, 8);
    checkOutput("t4_bp_ovf", rxOvf, 0);
    popOne(b);
    checkOutput("t4_bp_pop0", b, resp[0]);
    waitRxLevel(8, "t4_bp_refill");
    checkOutput("t4_bp_starts9", startLog.size() - startBase, 9);
    checkOutput("t4_bp_ovf_end", rxOvf, 0);
`else
    n = 0;
    while (bus.m_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) failBound("t4_done_wait");
    popOne(b);
    tick();
    checkOutput("t4_simul_pop0", b, resp[0]);
    checkOutput("t4_simul_level", rxLevel, 8);
    checkOutput("t4_simul_ovf", rxOvf, 0);
    checkOutput("t4_starts9", startLog.size() - startBase, 9);
    applyStimulus(8'h69);
    repeat (30) tick();
    checkOutput("t4_drop_starts", startLog.size() - startBase, 10);
    checkOutput("t4_drop_ovf", rxOvf, 1);
    checkOutput("t4_drop_level", rxLevel, 8);
`endif
    for (int i = 1; i <= 8; i++) begin
      popOne(b);
      checkOutput($sformatf("t4_drain_%0d", i), b, resp[i]);
    end
    checkOutput("t4_empty", rxLevel, 0);

    $display("[TB] WAIT timeout");
    doReset();
    neverDone = 1'b1;
    applyStimulus(8'h5A);
    n = 0;
    while (bus.m_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) failBound("t5_start_wait");
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 16) checkOutput("t5_tmo_early", tmoErr, 0);
    end
    checkOutput("t5_tmo_err", tmoErr, 1);
    checkOutput("t5_rx_level", rxLevel, 0);
    checkOutput("t5_idle", idle, 1);

    $display("[TB] reset mid-WAIT");
    doReset();
    neverDone = 1'b1;
    startBase = startLog.size();
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'hC0 + i));
    n = 0;
    while (startLog.size() < startBase + 1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) failBound("t6_start_wait");
    tick();
    checkOutput("t6_queued", txLevel, 3);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_tx_level", txLevel, 0);
    checkOutput("t6_m_start", bus.m_start, 0);
    checkOutput("t6_m_tx_data", bus.m_tx_data, 0);
    checkOutput("t6_idle", idle, 1);
    checkOutput("t6_in_ready", bus.in_ready, 1);
    checkOutput("t6_tmo_err", tmoErr, 0);
    neverDone = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    checkOutput("t6_no_restart", startLog.size() - startBase, 1);
    checkOutput("t6_idle_after", idle, 1);

    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end
endmodule
